// File: rtl/multiword_addsub_seq_pkg.sv
// Shared types and constants for the byte-serial multi-precision add/subtract sequencer.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int BYTE_W = 8;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/multiword_addsub_seq_byte_addsub.sv
// Pure 8-bit adder with carry-in/carry-out; the sequencer supplies any inversions.
module byte_addsub
   import addsub_pkg::*;
(
   input  logic [BYTE_W-1:0] I0,
   input  logic [BYTE_W-1:0] I1,
   input  logic              CIN,
   output logic [BYTE_W-1:0] O,
   output logic              COUT
);

   logic [BYTE_W:0] sum;

   assign sum       = {1'b0, I0} + {1'b0, I1} + {{BYTE_W{1'b0}}, CIN};
   assign {COUT, O} = sum;

endmodule

// File: rtl/multiword_addsub_seq.sv
// Byte-serial multi-precision add/subtract: one shared 8-bit core driven LSB first,
// with the carry chained through a register between cycles.
module multiword_addsub_seq
   import addsub_pkg::*;
#(
   parameter int WORDS = 4
)(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [8*WORDS-1:0]    A,
   input  logic [8*WORDS-1:0]    B,
   input  logic                  SUB,
   input  logic                  CIN,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [8*WORDS-1:0]    O,
   output logic                  COUT,
   output logic                  V
);

   localparam int            KW     = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] LAST_K = KW'(WORDS - 1);

   state_t state_reg, state_next;

   logic [WORDS-1:0][BYTE_W-1:0] a_reg, b_reg, o_reg;
   logic                         sub_reg;
   logic                         carry_reg;
   logic                         cout_reg;
   logic                         v_reg;
   logic [KW-1:0]                k_reg;

   logic [BYTE_W-1:0] core_i0, core_i1, core_o;
   logic              core_cout;
   logic              last_byte;
   logic              v_next;

   // Subtract is A + ~B + ~CIN, so the B inversion happens here and the core stays an adder.
   assign core_i0   = a_reg[k_reg];
   assign core_i1   = (sub_reg == OP_SUB) ? ~b_reg[k_reg] : b_reg[k_reg];
   assign last_byte = (k_reg == LAST_K);
   assign v_next    = (a_reg[WORDS-1][BYTE_W-1] == core_i1[BYTE_W-1]) &&
                      (core_o[BYTE_W-1] != a_reg[WORDS-1][BYTE_W-1]);

   byte_addsub u_core (
      .I0   (core_i0),
      .I1   (core_i1),
      .CIN  (carry_reg),
      .O    (core_o),
      .COUT (core_cout)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      IN_READY   = 1'b0;
      OUT_VALID  = 1'b0;
      case (state_reg)
         IDLE: begin
            IN_READY = 1'b1;
            if (IN_VALID) state_next = RUN;
         end
         RUN: begin
            if (last_byte) state_next = DONE;
         end
         DONE: begin
            OUT_VALID = 1'b1;
            if (OUT_READY) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         a_reg     <= '0;
         b_reg     <= '0;
         o_reg     <= '0;
         sub_reg   <= 1'b0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         v_reg     <= 1'b0;
         k_reg     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (IN_VALID) begin
                  a_reg     <= A;
                  b_reg     <= B;
                  sub_reg   <= SUB;
                  k_reg     <= '0;
                  carry_reg <= (SUB == OP_SUB) ? ~CIN : CIN;
               end
            end
            RUN: begin
               o_reg[k_reg] <= core_o;
               carry_reg    <= core_cout;
               if (last_byte) begin
                  cout_reg <= core_cout;
                  v_reg    <= v_next;
               end else begin
                  k_reg <= k_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign O    = o_reg;
   assign COUT = cout_reg;
   assign V    = v_reg;

endmodule

// File: doc/multiword_addsub_seq.md
# multiword_addsub_seq

Byte-serial multi-precision add/subtract sequencer. It accepts a pair of `8*WORDS`-bit operands and drives a single shared 8-bit carry-in/carry-out adder/subtractor core once per byte, LSB first, carrying the carry through a register between cycles. It sits between a requester issuing wide arithmetic ops and the narrow byte datapath, so the wide adder is replaced by one 8-bit core plus sequencing.

## Interface

Parameters:
- `WORDS`, default 4: operand width in bytes; legal range 1..16.

Ports:
- `CLK`  in  1  sole clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `IN_VALID`  in  1  request valid.
- `IN_READY`  out  1  block can accept a request.
- `A`  in  8*WORDS  minuend / addend.
- `B`  in  8*WORDS  subtrahend / addend.
- `SUB`  in  1  0 = add, 1 = subtract.
- `CIN`  in  1  carry-in for add; borrow-in for subtract.
- `OUT_VALID`  out  1  result valid.
- `OUT_READY`  in  1  consumer takes result.
- `O`  out  8*WORDS  result.
- `COUT`  out  1  carry out of MSB (subtract: 1 = no borrow).
- `V`  out  1  signed two's-complement overflow.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - `IN_READY`=1.
  - On `IN_VALID`, latch `A`, `B`, `SUB`, clear the byte index `k` to 0, and load the carry register with `CIN` for add or `~CIN` for subtract.
  - Go to RUN.
- RUN, one byte per cycle:
  - Core inputs: `I0`=A[k], `I1`=B[k] for add or ~B[k] for subtract, `CIN`=carry register.
  - Core sum goes to O[k]; core carry-out goes to the carry register.
  - On `k`=WORDS-1, capture the final carry into `COUT`, compute `V`, and go to DONE. Otherwise increment `k`.
- DONE:
  - `OUT_VALID`=1; `O`, `COUT` and `V` are held stable.
  - On `OUT_READY`, go to IDLE.
- Arithmetic, exact modulo 2^(8*WORDS):
  - Add: O = A + B + CIN.
  - Subtract: O = A − B − CIN, implemented as A + ~B + ~CIN.
  - COUT is the raw carry, not an inverted borrow.
- V = (a_msb == b'_msb) & (o_msb != a_msb), where b' is the effective (inverted for subtract) B.
- `IN_READY` is 0 outside IDLE. Requests are never queued; inputs are sampled only at acceptance, and changes to `A`/`B` after acceptance have no effect.
- `O` bytes not yet written in RUN hold their previous values. `O` is only defined while `OUT_VALID`=1.

## Timing

- Reset:
  - Synchronous, takes effect at the next edge regardless of state and aborts any operation in flight.
  - Goes to IDLE; `O`=0, `COUT`=0, `V`=0, `OUT_VALID`=0, `IN_READY`=1 in the cycle after the reset edge, carry register=0, `k`=0.
  - `RESET` takes priority over `IN_VALID` in the same cycle.
- Latency and throughput:
  - Accept at edge t.
  - RUN occupies edges t+1 … t+WORDS.
  - `OUT_VALID` is high from t+WORDS.
  - Minimum issue interval: WORDS+2 cycles, because there is one IDLE cycle after DONE.
- WORDS=1: one RUN cycle; behaviour is identical to a single Sub8/Add8 with carry.
- Backpressure: DONE holds indefinitely while `OUT_READY`=0.
- `OUT_READY` in any state other than DONE is ignored.
- `k` width is max(1, clog2(WORDS)). `k` never exceeds WORDS-1; wrap is not reachable.

## Structure

- Shared package `addsub_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - byte width constant 8.
  - op encoding constants ADD=0, SUB=1.
- Sub-module `byte_addsub`:
  - 8-bit adder with `I0`, `I1`, `CIN`, `O`, `COUT`; the sum is 9 bits wide, split into `O` and `COUT`.
  - Instantiated once.
  - The sequencer supplies the inversions, so the core stays a pure adder.
- The top module holds the FSM, operand/result registers, carry register and index counter.

## Test plan

All scenarios use WORDS=4.

- Reset then idle → `IN_READY`=1, `OUT_VALID`=0, `O`=0, `COUT`=0, `V`=0.
- Add A=0x000000FF, B=0x00000001, CIN=0 → O=0x00000100, COUT=0, V=0; `OUT_VALID` rises exactly 4 cycles after accept.
- Subtract A=0x00000000, B=0x00000001, CIN=0 → O=0xFFFFFFFF, COUT=0 (borrow), V=0. Subtract A=5, B=3, CIN=1 → O=1, COUT=1.
- Signed overflow:
  - Add A=0x7FFFFFFF, B=1 → O=0x80000000, V=1, COUT=0.
  - Add A=0xFFFFFFFF, B=1, CIN=1 → O=0x00000001, COUT=1, V=0.
- Backpressure and handshake:
  - Hold `OUT_READY`=0 for 10 cycles → `OUT_VALID` and `O` stable, `IN_READY`=0.
  - Pulse `OUT_READY` → IDLE next cycle; a new request with `IN_VALID` held high is accepted one cycle later.
- Assert `RESET` during the 2nd RUN cycle → next cycle is IDLE with all outputs 0; a following op completes correctly with no stale carry.
